// File: rtl/led_chaser_pkg.sv
// Shared encodings for the running-light controller: FSM states and key indices.
package led_chaser_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_STOP   = 3'd0;
  localparam state_t ST_LEFT   = 3'd1;
  localparam state_t ST_RIGHT  = 3'd2;
  localparam state_t ST_BNC_UP = 3'd3;
  localparam state_t ST_BNC_DN = 3'd4;

  localparam int KEY_STOP   = 0;
  localparam int KEY_LEFT   = 1;
  localparam int KEY_RIGHT  = 2;
  localparam int KEY_BOUNCE = 3;
  localparam int N_KEYS     = 4;

endpackage

// File: rtl/key_debounce.sv
// Debounces one active-low raw key and emits a single-cycle press pulse.
// The pulse appears DEBOUNCE_CYC+1 cycles after the key settles low; release is silent.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [CW-1:0] cnt;
  logic          stable;
  logic          stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      stable      <= 1'b1;
      stable_d    <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      stable_d    <= stable;
      press_pulse <= stable_d & ~stable;
      // Any cycle where raw agrees with the accepted level restarts the count.
      if (key_n == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt    <= '0;
        stable <= key_n;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_chaser_ctrl.sv
// Running-light controller: rotate left/right or ping-pong an N_LED pattern at a
// selectable step rate, commanded by four debounced active-low keys.
module led_chaser_ctrl
  import led_chaser_pkg::*;
#(
  parameter int               N_LED        = 8,
  parameter int               BASE_PERIOD  = 50_000_000,
  parameter int               DEBOUNCE_CYC = 1_000_000,
  parameter logic [N_LED-1:0] PATTERN_INIT = {{(N_LED-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_stop_n,
  input  logic             key_left_n,
  input  logic             key_right_n,
  input  logic             key_bounce_n,
  input  logic [1:0]       speed_sel,
  output logic [N_LED-1:0] led,
  output logic [2:0]       mode_o,
  output logic             step_o
);

  localparam int TW = $clog2(BASE_PERIOD + 1);

  logic [N_KEYS-1:0] press;
  state_t            state;
  state_t            cmd_state;
  logic              cmd_chg;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     period;
  logic [TW-1:0]     period_m1;
  logic [1:0]        speed_q;
  logic              speed_chg;
  logic              run;
  logic              tick;
  logic              timer_clr;
  logic [N_LED-1:0]  rotl;
  logic [N_LED-1:0]  rotr;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_stop (
    .clk(clk), .rst_n(rst_n), .key_n(key_stop_n), .press_pulse(press[KEY_STOP])
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left (
    .clk(clk), .rst_n(rst_n), .key_n(key_left_n), .press_pulse(press[KEY_LEFT])
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (
    .clk(clk), .rst_n(rst_n), .key_n(key_right_n), .press_pulse(press[KEY_RIGHT])
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_bounce (
    .clk(clk), .rst_n(rst_n), .key_n(key_bounce_n), .press_pulse(press[KEY_BOUNCE])
  );

  // Priority stop > left > right > bounce; a press that names the current state is a no-op.
  always_comb begin
    cmd_state = state;
    if (press[KEY_STOP]) begin
      cmd_state = ST_STOP;
    end else if (press[KEY_LEFT]) begin
      cmd_state = ST_LEFT;
    end else if (press[KEY_RIGHT]) begin
      cmd_state = ST_RIGHT;
    end else if (press[KEY_BOUNCE]) begin
      if (state != ST_BNC_UP && state != ST_BNC_DN) begin
        cmd_state = led[N_LED-1] ? ST_BNC_DN : ST_BNC_UP;
      end
    end
  end

  assign cmd_chg   = (cmd_state != state);
  assign speed_chg = (speed_sel != speed_q);
  assign period    = TW'(BASE_PERIOD) >> speed_sel;
  assign period_m1 = (period == '0) ? '0 : period - TW'(1);
  assign run       = (state != ST_STOP);
  assign tick      = run && !cmd_chg && !speed_chg && (timer >= period_m1);
  assign timer_clr = !run || cmd_chg || speed_chg || tick;
  assign rotl      = {led[N_LED-2:0], led[N_LED-1]};
  assign rotr      = {led[0], led[N_LED-1:1]};
  assign mode_o    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      led     <= PATTERN_INIT;
      step_o  <= 1'b0;
      timer   <= '0;
      speed_q <= '0;
    end else begin
      speed_q <= speed_sel;
      step_o  <= tick;
      timer   <= timer_clr ? '0 : timer + TW'(1);
      if (cmd_chg) begin
        state <= cmd_state;
      end else if (tick) begin
        case (state)
          ST_LEFT:  led <= rotl;
          ST_RIGHT: led <= rotr;
          ST_BNC_UP: begin
            led <= rotl;
            if (rotl[N_LED-1]) state <= ST_BNC_DN;
          end
          ST_BNC_DN: begin
            led <= rotr;
            if (rotr[0]) state <= ST_BNC_UP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
